efpga_offload_ctrl: RTL and testbench
=====================================

# efpga_offload_ctrl

Parametrised controller between the core's eFPGA operand/result port and the embedded FPGA fabric. It replaces the fixed 32-bit, three-result, delay-only core-to-fabric connection. It adds a request/grant/valid handshake, a selectable completion mode (fixed delay or fabric `done`), a timeout, result selection over N result channels, and flush. It sits inside the core top level, clocked by the gated core clock.

## Interface
- `DataWidth`, 32: operand and result width.
- `NumResults`, 3: number of fabric result channels. Range 1–8.
- `OpWidth`, 2: width of the operator code.
- `DelayWidth`, 4: width of the fixed-delay field.
- `TimeoutCycles`, 255: wait limit in `done` mode. Range 1–65535.
- `SelWidth`, derived: max(1, clog2(`NumResults`)).

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset. Asynchronous, active-low.
- `req_i` in 1: core requests an operation.
- `operand_a_i`, `operand_b_i` in `DataWidth`: operands.
- `operator_i` in `OpWidth`: operator code.
- `delay_i` in `DelayWidth`: fixed latency in delay mode.
- `use_done_i` in 1: 1 = complete on `efpga_done_i`; 0 = complete on delay expiry.
- `result_sel_i` in `SelWidth`: result channel to return.
- `flush_i` in 1: abort the current operation.
- `gnt_o` out 1: request accepted.
- `rvalid_o` out 1: response valid, one-cycle pulse.
- `rdata_o` out `DataWidth`: response data.
- `err_o` out 1: response error. Qualified by `rvalid_o`.
- `busy_o` out 1: controller not in IDLE.
- `efpga_operand_a_o`, `efpga_operand_b_o` out `DataWidth`: operands to the fabric.
- `efpga_operator_o` out `OpWidth`; `efpga_delay_o` out `DelayWidth`.
- `efpga_en_o` out 1; `efpga_write_strobe_o` out 1.
- `efpga_result_i` in `NumResults`×`DataWidth`: channel k occupies bits [k·DW +: DW].
- `efpga_done_i` in 1: fabric completion.
- `stat_ops_o` out 16; `stat_timeouts_o` out 16: statistics (see Configuration).

## Operation
- Reset: state IDLE. Every output and internal register is 0.
- FSM states: IDLE, STROBE, WAIT, RESP.
- IDLE:
  - `gnt_o = req_i`, combinational.
  - On `req_i`, latch operands, operator, delay, mode and select into the `efpga_*` output registers.
  - If `result_sel_i >= NumResults`: go to RESP with err pending. No fabric strobe is issued.
  - Otherwise go to STROBE.
- STROBE:
  - `efpga_write_strobe_o = 1` for exactly one cycle; `efpga_en_o = 1`.
  - Counter loads the latched delay in delay mode, or `TimeoutCycles` in `done` mode.
  - Next state is WAIT.
- WAIT (`efpga_en_o = 1`):
  - Delay mode: if counter == 0, capture the selected result into `rdata_o` and go to RESP. Otherwise decrement.
  - `done` mode: if `efpga_done_i`, capture and go to RESP. Else if counter == 0, set `rdata_o = 0`, set err, and go to RESP. Else decrement.
  - When `efpga_done_i` and counter == 0 occur in the same cycle, `done` wins and there is no error.
  - `efpga_done_i` outside WAIT is ignored.
- RESP: `rvalid_o = 1` with `err_o` for one cycle, then IDLE. `req_i` is not granted in RESP.
- Flush:
  - `flush_i` in any non-IDLE state forces IDLE next cycle.
  - `efpga_en_o` drops and no `rvalid_o` is produced.
  - A flush in the same cycle as RESP still lets that `rvalid_o` pulse complete.
  - In IDLE, `flush_i` takes priority over `req_i`: `gnt_o = 0`.
- `efpga_operand_*`, `efpga_operator_o` and `efpga_delay_o` hold their values until the next grant.
- `rdata_o` holds its value until the next capture.

## Timing
- Grant in cycle 0.
- Delay mode: strobe in cycle 1; WAIT occupies cycles 2..2+D; `rvalid_o` in cycle 3+D. The result is sampled in cycle 2+D.
- `done` mode: `efpga_done_i` sampled in cycle k ≥ 2 gives `rvalid_o` in cycle k+1.
- Timeout: `rvalid_o`+`err_o` in cycle 3+`TimeoutCycles`.
- Bad select: `rvalid_o`+`err_o` in cycle 1.
- Back-to-back: the earliest next grant is the cycle after RESP.
- Counter width is clog2(max(2^`DelayWidth`, `TimeoutCycles`+1)).
- Asynchronous reset mid-operation returns to IDLE immediately: all outputs 0, no response.

## Configuration
- `EFPGA_OFFLOAD_STATS_EN` defined:
  - `stat_ops_o` increments on every `rvalid_o` without error. It is 16-bit and wraps.
  - `stat_timeouts_o` increments on every timeout error. It saturates at 0xFFFF.
  - Both reset to 0.
- Undefined: both ports tie to 0 and no counter logic is built.

## Test plan
- Delay mode: a=5, b=7, D=3, sel=1, result1=0x12. Required: `gnt_o` in cycle 0, strobe in cycle 1, `rvalid_o` in cycle 6, `rdata_o`=0x12, `err_o`=0.
- Delay boundary: D=0 → `rvalid_o` in cycle 3. D=15 → `rvalid_o` in cycle 18.
- `done` mode: `done` in cycle 4 → `rvalid_o` in cycle 5 with the selected channel's data. `done` pulsed in cycle 1 (STROBE) → ignored.
- Timeout: `TimeoutCycles`=10, no `done` → `rvalid_o`+`err_o` in cycle 13, `rdata_o`=0, `stat_timeouts_o`=1. `done` in cycle 12 (counter 0) → no error.
- Bad select: `NumResults`=3, sel=3 → `rvalid_o`+`err_o` in cycle 1, `efpga_write_strobe_o` never asserted.
- Flush in WAIT at cycle 3 → IDLE in cycle 4, no `rvalid_o`, `busy_o`=0. `req_i` in cycle 4 is granted. Reset mid-WAIT → all outputs 0.

Source files
------------

// File: rtl/efpga_offload_ctrl.sv
// Core-to-eFPGA offload controller: req/gnt handshake, strobe, delay- or done-based
// completion with timeout, N-channel result select and flush. Define EFPGA_OFFLOAD_STATS_EN for counters.
module efpga_offload_ctrl #(
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned NumResults    = 3,
    parameter int unsigned OpWidth       = 2,
    parameter int unsigned DelayWidth    = 4,
    parameter int unsigned TimeoutCycles = 255,
    parameter int unsigned SelWidth      = (NumResults > 1) ? $clog2(NumResults) : 1
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              req_i,
    input  logic [DataWidth-1:0]              operand_a_i,
    input  logic [DataWidth-1:0]              operand_b_i,
    input  logic [OpWidth-1:0]                operator_i,
    input  logic [DelayWidth-1:0]             delay_i,
    input  logic                              use_done_i,
    input  logic [SelWidth-1:0]               result_sel_i,
    input  logic                              flush_i,
    output logic                              gnt_o,
    output logic                              rvalid_o,
    output logic [DataWidth-1:0]              rdata_o,
    output logic                              err_o,
    output logic                              busy_o,
    output logic [DataWidth-1:0]              efpga_operand_a_o,
    output logic [DataWidth-1:0]              efpga_operand_b_o,
    output logic [OpWidth-1:0]                efpga_operator_o,
    output logic [DelayWidth-1:0]             efpga_delay_o,
    output logic                              efpga_en_o,
    output logic                              efpga_write_strobe_o,
    input  logic [NumResults*DataWidth-1:0]   efpga_result_i,
    input  logic                              efpga_done_i,
    output logic [15:0]                       stat_ops_o,
    output logic [15:0]                       stat_timeouts_o
);

    localparam int unsigned MaxCount = ((2 ** DelayWidth) > (TimeoutCycles + 1)) ?
                                       (2 ** DelayWidth) : (TimeoutCycles + 1);
    localparam int unsigned CntWidth = $clog2(MaxCount);
    localparam logic [SelWidth:0] NumResW = (SelWidth + 1)'(NumResults);

    typedef enum logic [1:0] {IDLE, STROBE, WAIT, RESP} state_e;

    state_e                  state_q;
    logic [DataWidth-1:0]    op_a_q, op_b_q, rdata_q;
    logic [OpWidth-1:0]      operator_q;
    logic [DelayWidth-1:0]   delay_q;
    logic                    use_done_q;
    logic [SelWidth-1:0]     sel_q;
    logic                    en_q, strobe_q, rvalid_q, err_q;
    logic [CntWidth-1:0]     cnt_q;
    logic [DataWidth-1:0]    sel_data;
    logic                    bad_sel;

    assign bad_sel = {1'b0, result_sel_i} >= NumResW;

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < int'(NumResults); k++) begin
            if (sel_q == SelWidth'(k)) begin
                sel_data = efpga_result_i[k*DataWidth +: DataWidth];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            op_a_q     <= '0;
            op_b_q     <= '0;
            operator_q <= '0;
            delay_q    <= '0;
            use_done_q <= 1'b0;
            sel_q      <= '0;
            en_q       <= 1'b0;
            strobe_q   <= 1'b0;
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            cnt_q      <= '0;
        end else begin
            strobe_q <= 1'b0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_i && !flush_i) begin
                        op_a_q     <= operand_a_i;
                        op_b_q     <= operand_b_i;
                        operator_q <= operator_i;
                        delay_q    <= delay_i;
                        use_done_q <= use_done_i;
                        sel_q      <= result_sel_i;
                        if (bad_sel) begin
                            // Out-of-range channel: answer with an error, never touch the fabric
                            state_q  <= RESP;
                            rvalid_q <= 1'b1;
                            err_q    <= 1'b1;
                        end else begin
                            state_q  <= STROBE;
                            strobe_q <= 1'b1;
                            en_q     <= 1'b1;
                        end
                    end
                end
                STROBE: begin
                    if (flush_i) begin
                        state_q <= IDLE;
                        en_q    <= 1'b0;
                    end else begin
                        cnt_q   <= use_done_q ? CntWidth'(TimeoutCycles) : CntWidth'(delay_q);
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (flush_i) begin
                        state_q <= IDLE;
                        en_q    <= 1'b0;
                    end else if ((use_done_q && efpga_done_i) || (!use_done_q && cnt_q == '0)) begin
                        rdata_q  <= sel_data;
                        rvalid_q <= 1'b1;
                        en_q     <= 1'b0;
                        state_q  <= RESP;
                    end else if (cnt_q == '0) begin
                        rdata_q  <= '0;
                        rvalid_q <= 1'b1;
                        err_q    <= 1'b1;
                        en_q     <= 1'b0;
                        state_q  <= RESP;
                    end else begin
                        cnt_q <= cnt_q - CntWidth'(1);
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    en_q    <= 1'b0;
                end
            endcase
        end
    end

    assign gnt_o                = (state_q == IDLE) && req_i && !flush_i;
    assign busy_o               = (state_q != IDLE);
    assign rvalid_o             = rvalid_q;
    assign err_o                = err_q;
    assign rdata_o              = rdata_q;
    assign efpga_operand_a_o    = op_a_q;
    assign efpga_operand_b_o    = op_b_q;
    assign efpga_operator_o     = operator_q;
    assign efpga_delay_o        = delay_q;
    assign efpga_en_o           = en_q;
    assign efpga_write_strobe_o = strobe_q;

`ifdef EFPGA_OFFLOAD_STATS_EN
    logic [15:0] stat_ops_q, stat_ops_d;
    logic [15:0] stat_to_q, stat_to_d;
    logic        timeout_evt;

    // Same condition that drives the timeout branch of WAIT
    assign timeout_evt = (state_q == WAIT) && use_done_q && !flush_i &&
                         !efpga_done_i && (cnt_q == '0);

    always_comb begin
        stat_ops_d = stat_ops_q;
        stat_to_d  = stat_to_q;
        if (rvalid_q && !err_q) begin
            stat_ops_d = stat_ops_q + 16'd1;
        end
        if (timeout_evt && (stat_to_q != 16'hFFFF)) begin
            stat_to_d = stat_to_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_ops_q <= '0;
            stat_to_q  <= '0;
        end else begin
            stat_ops_q <= stat_ops_d;
            stat_to_q  <= stat_to_d;
        end
    end

    assign stat_ops_o      = stat_ops_q;
    assign stat_timeouts_o = stat_to_q;
`else
    assign stat_ops_o      = '0;
    assign stat_timeouts_o = '0;
`endif

endmodule

// File: tb/tb_efpga_offload_ctrl.sv
// Directed bench for efpga_offload_ctrl (NumResults=3, TimeoutCycles=10); cycle 0 is the grant cycle.
module tb_efpga_offload_ctrl;

`ifdef EFPGA_OFFLOAD_STATS_EN
    localparam bit Stats = 1'b1;
`else
    localparam bit Stats = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_i = 1'b0;
    logic [31:0] operand_a_i = '0, operand_b_i = '0;
    logic [1:0]  operator_i = '0;
    logic [3:0]  delay_i = '0;
    logic        use_done_i = 1'b0;
    logic [1:0]  result_sel_i = '0;
    logic        flush_i = 1'b0;
    logic        gnt_o, rvalid_o, err_o, busy_o;
    logic [31:0] rdata_o, efpga_operand_a_o, efpga_operand_b_o;
    logic [1:0]  efpga_operator_o;
    logic [3:0]  efpga_delay_o;
    logic        efpga_en_o, efpga_write_strobe_o;
    logic [95:0] efpga_result_i = {32'h0000_5C5C, 32'h0000_0012, 32'h0000_00A0};
    logic        efpga_done_i = 1'b0;
    logic [15:0] stat_ops_o, stat_timeouts_o;

    int n_checks = 0;
    int n_fail   = 0;

    efpga_offload_ctrl #(
        .DataWidth(32), .NumResults(3), .OpWidth(2), .DelayWidth(4), .TimeoutCycles(10)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i),
        .operand_a_i(operand_a_i), .operand_b_i(operand_b_i), .operator_i(operator_i),
        .delay_i(delay_i), .use_done_i(use_done_i), .result_sel_i(result_sel_i),
        .flush_i(flush_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .err_o(err_o), .busy_o(busy_o),
        .efpga_operand_a_o(efpga_operand_a_o), .efpga_operand_b_o(efpga_operand_b_o),
        .efpga_operator_o(efpga_operator_o), .efpga_delay_o(efpga_delay_o),
        .efpga_en_o(efpga_en_o), .efpga_write_strobe_o(efpga_write_strobe_o),
        .efpga_result_i(efpga_result_i), .efpga_done_i(efpga_done_i),
        .stat_ops_o(stat_ops_o), .stat_timeouts_o(stat_timeouts_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, required end before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs are driven 1 time unit after the rising edge; outputs are sampled 4 units later.
    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op, input logic [3:0] d, input logic ud,
                          input logic [1:0] sel, input int done_cyc, input int stray_cyc,
                          output int rv_cyc, output logic [31:0] rd, output logic er,
                          output int st_cyc, output int st_cnt, output logic g0);
        int c;
        rv_cyc = -1; rd = '0; er = 1'b0; st_cyc = -1; st_cnt = 0;
        req_i = 1'b1; operand_a_i = a; operand_b_i = b; operator_i = op;
        delay_i = d; use_done_i = ud; result_sel_i = sel;
        efpga_done_i = (done_cyc == 0); flush_i = 1'b0;
        #4;
        g0 = gnt_o;
        c = 0;
        while (rv_cyc < 0 && c < 40) begin
            if (efpga_write_strobe_o) begin
                st_cnt++;
                if (st_cyc < 0) st_cyc = c;
            end
            if (rvalid_o) begin
                rv_cyc = c; rd = rdata_o; er = err_o;
            end else begin
                next_cycle();
                c++;
                req_i = 1'b0;
                efpga_done_i = (c == done_cyc) || (c == stray_cyc);
                #4;
            end
        end
        next_cycle();
        efpga_done_i = 1'b0;
        $display("txn %s: gnt=%0b strobe_cyc=%0d strobes=%0d rvalid_cyc=%0d rdata=%0h err=%0b",
                 name, g0, st_cyc, st_cnt, rv_cyc, rd, er);
    endtask

    initial begin
        int rv, sc, sn, hit;
        logic [31:0] rd;
        logic er, g0;

        next_cycle();
        next_cycle();
        #4;
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_rvalid", 64'(rvalid_o), 64'd0);
        chk("rst_en", 64'(efpga_en_o), 64'd0);
        chk("rst_strobe", 64'(efpga_write_strobe_o), 64'd0);
        chk("rst_rdata", 64'(rdata_o), 64'd0);
        chk("rst_opa", 64'(efpga_operand_a_o), 64'd0);
        next_cycle();
        rst_ni = 1'b1;
        next_cycle();

        run_op("delay3", 32'd5, 32'd7, 2'd2, 4'd3, 1'b0, 2'd1, -1, -1, rv, rd, er, sc, sn, g0);
        chk("d3_gnt", 64'(g0), 64'd1);
        chk("d3_strobe_cyc", 64'(sc), 64'd1);
        chk("d3_strobe_cnt", 64'(sn), 64'd1);
        chk("d3_rvalid_cyc", 64'(rv), 64'd6);
        chk("d3_rdata", 64'(rd), 64'h12);
        chk("d3_err", 64'(er), 64'd0);
        chk("d3_opa", 64'(efpga_operand_a_o), 64'd5);
        chk("d3_opb", 64'(efpga_operand_b_o), 64'd7);
        chk("d3_operator", 64'(efpga_operator_o), 64'd2);
        chk("d3_delay", 64'(efpga_delay_o), 64'd3);

        run_op("delay0", 32'd1, 32'd2, 2'd0, 4'd0, 1'b0, 2'd0, -1, -1, rv, rd, er, sc, sn, g0);
        chk("d0_rvalid_cyc", 64'(rv), 64'd3);
        chk("d0_rdata", 64'(rd), 64'hA0);

        run_op("delay15", 32'd3, 32'd4, 2'd1, 4'd15, 1'b0, 2'd2, -1, -1, rv, rd, er, sc, sn, g0);
        chk("d15_rvalid_cyc", 64'(rv), 64'd18);
        chk("d15_rdata", 64'(rd), 64'h5C5C);

        run_op("done4", 32'd9, 32'd9, 2'd3, 4'd0, 1'b1, 2'd2, 4, 1, rv, rd, er, sc, sn, g0);
        chk("done4_rvalid_cyc", 64'(rv), 64'd5);
        chk("done4_rdata", 64'(rd), 64'h5C5C);
        chk("done4_err", 64'(er), 64'd0);

        run_op("timeout", 32'd1, 32'd1, 2'd0, 4'd0, 1'b1, 2'd1, -1, -1, rv, rd, er, sc, sn, g0);
        chk("to_rvalid_cyc", 64'(rv), 64'd13);
        chk("to_err", 64'(er), 64'd1);
        chk("to_rdata", 64'(rd), 64'd0);
        chk("to_stat", 64'(stat_timeouts_o), Stats ? 64'd1 : 64'd0);

        run_op("done12", 32'd1, 32'd1, 2'd0, 4'd0, 1'b1, 2'd1, 12, -1, rv, rd, er, sc, sn, g0);
        chk("done12_rvalid_cyc", 64'(rv), 64'd13);
        chk("done12_err", 64'(er), 64'd0);
        chk("done12_rdata", 64'(rd), 64'h12);

        run_op("badsel", 32'd1, 32'd1, 2'd0, 4'd2, 1'b0, 2'd3, -1, -1, rv, rd, er, sc, sn, g0);
        chk("bad_gnt", 64'(g0), 64'd1);
        chk("bad_rvalid_cyc", 64'(rv), 64'd1);
        chk("bad_err", 64'(er), 64'd1);
        chk("bad_strobe_cnt", 64'(sn), 64'd0);

        // Flush in WAIT at cycle 3, then a new request in cycle 4
        hit = 0;
        req_i = 1'b1; delay_i = 4'd5; use_done_i = 1'b0; result_sel_i = 2'd0; operand_a_i = 32'd11;
        #4;
        chk("fl_gnt0", 64'(gnt_o), 64'd1);
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            req_i = 1'b0;
            flush_i = (c == 3);
            #4;
            if (rvalid_o) hit++;
        end
        chk("fl_busy_c3", 64'(busy_o), 64'd1);
        next_cycle();
        flush_i = 1'b0;
        req_i = 1'b1; delay_i = 4'd0; result_sel_i = 2'd1; operand_a_i = 32'd22;
        #4;
        if (rvalid_o) hit++;
        chk("fl_busy_c4", 64'(busy_o), 64'd0);
        chk("fl_en_c4", 64'(efpga_en_o), 64'd0);
        chk("fl_no_rvalid", 64'(hit), 64'd0);
        chk("fl_gnt_c4", 64'(gnt_o), 64'd1);
        rv = -1;
        for (int c = 5; c <= 12; c++) begin
            next_cycle();
            req_i = 1'b0;
            #4;
            if (rvalid_o && rv < 0) begin
                rv = c;
                rd = rdata_o;
            end
        end
        chk("fl_next_rvalid_cyc", 64'(rv), 64'd7);
        chk("fl_next_rdata", 64'(rd), 64'h12);
        chk("fl_next_opa", 64'(efpga_operand_a_o), 64'd22);
        $display("txn flush: follow-up rvalid_cyc=%0d rdata=%0h", rv, rd);

        chk("stat_ops", 64'(stat_ops_o), Stats ? 64'd6 : 64'd0);

        // Asynchronous reset in the middle of WAIT
        next_cycle();
        req_i = 1'b1; delay_i = 4'd10; use_done_i = 1'b0; result_sel_i = 2'd2; operand_a_i = 32'd33;
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            req_i = 1'b0;
        end
        #4;
        chk("rmid_en_before", 64'(efpga_en_o), 64'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("rmid_en", 64'(efpga_en_o), 64'd0);
        chk("rmid_busy", 64'(busy_o), 64'd0);
        chk("rmid_opa", 64'(efpga_operand_a_o), 64'd0);
        chk("rmid_delay", 64'(efpga_delay_o), 64'd0);
        chk("rmid_rdata", 64'(rdata_o), 64'd0);
        chk("rmid_rvalid", 64'(rvalid_o), 64'd0);
        chk("rmid_stat_ops", 64'(stat_ops_o), 64'd0);
        next_cycle();
        rst_ni = 1'b1;
        hit = 0;
        for (int c = 0; c < 15; c++) begin
            next_cycle();
            #4;
            if (rvalid_o) hit++;
        end
        chk("rmid_no_rvalid", 64'(hit), 64'd0);
        $display("txn reset_mid_wait: rvalid pulses after reset=%0d", hit);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
